// File: rtl/lfsr8_checker.sv
// lfsr8_checker: self-synchronising 8-bit Fibonacci LFSR pattern checker with saturating error count.
// Optional lock-up (all-zero word) fault detection is enabled by defining LFSR8_CHK_ZERO_EN.
module lfsr8_checker #(
    parameter logic [7:0] TAPS     = 8'hB8,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic [7:0]  din,
    input  logic        clr_err,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [1:0]  state_o,
    output logic        zero_seen
);
    typedef enum logic [1:0] {HUNT = 2'b00, SYNC = 2'b01, LOCKED = 2'b10} state_t;
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
    state_t     state;
    logic [7:0] pred;
    logic [3:0] match, miss;
    logic       hit, zero, zfault, err_hit;
    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], ^(x & TAPS)};
    endfunction
    assign hit     = din == pred;
    assign zero    = din == 8'h00;
    assign err_hit = din_valid && state == LOCKED && !hit;
    assign state_o = state;
`ifdef LFSR8_CHK_ZERO_EN
    assign zfault = din_valid && zero && state != HUNT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_seen <= 1'b0;
        else zero_seen <= clr_err ? 1'b0 : zero_seen | zfault;
    end
`else
    assign zfault    = 1'b0;
    assign zero_seen = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            pred      <= 8'h00;
            match     <= 4'd0;
            miss      <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 16'h0000;
        end else begin
            err_pulse <= err_hit;
            if (clr_err) err_cnt <= 16'h0000;
            else if (err_hit && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (din_valid) begin
                case (state)
                    HUNT: if (!zero) begin
                        pred  <= nxt(din);
                        match <= 4'd0;
                        state <= SYNC;
                    end
                    SYNC: if (zero) begin
                        state <= HUNT;
                    end else if (hit) begin
                        pred  <= nxt(pred);
                        match <= match + 4'd1;
                        if (match + 4'd1 == LOCK_N) begin
                            state  <= LOCKED;
                            miss   <= 4'd0;
                            locked <= 1'b1;
                        end
                    end else begin
                        pred  <= nxt(din);
                        match <= 4'd0;
                    end
                    LOCKED: begin
                        // flywheel: prediction free-runs so a corrupted word cannot reseed it
                        pred <= nxt(pred);
                        if (zfault || (!hit && miss + 4'd1 == LOSS_N)) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                        miss <= hit ? 4'd0 : miss + 4'd1;
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
